timer_display_driver: RTL and testbench
=======================================

Name: timer_display_driver

Overview:
Downstream consumer of the 30-to-0 BCD countdown stage. It takes the dozens/units digits and the time-over flag and drives a two-digit, time-multiplexed, active-low 7-segment display. The block scans the two digits with anti-ghosting gaps, optionally blanks a leading zero, and blinks "00" while time is over. It sits between the countdown counter and the board display pins.

Parameters:
SCAN_CYCLES, 50000, clock cycles each digit is lit per scan slot (must be >= 2)
BLINK_CYCLES, 12500000, clock cycles per blink half-period while time_over is high (must be >= 2)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
dozens  input  2  BCD tens digit from countdown stage (0..3)
units  input  4  BCD units digit from countdown stage (0..9)
time_over  input  1  high when countdown reached 00
blank_leading  input  1  1 = suppress dozens digit when it is 0
seg  output  7  segments, seg[0]=a .. seg[6]=g, active-low
an  output  2  digit enables, an[0]=units, an[1]=dozens, active-low

Behaviour:
- Reset: synchronous, active-high, dominates all other inputs. After reset: seg=7'h7F, an=2'b11, scan FSM in UNITS, dwell counter=0, blink counter=0, blink phase=ON, input registers=0.
- Input capture: dozens, units and time_over are registered every cycle. All outputs are registered. Total input-to-pin latency is 2 cycles while the relevant digit is lit.
- Scan FSM, four states in a cyclic order UNITS -> GAP0 -> DOZENS -> GAP1 -> UNITS:
  - UNITS and DOZENS each last SCAN_CYCLES cycles.
  - GAP0 and GAP1 each last exactly 1 cycle, with an=2'b11 and seg=7'h7F.
  - Full period = 2*SCAN_CYCLES+2 cycles. The dwell counter resets to 0 on every state change.
- Digit select: in UNITS, an=2'b10 and seg=decode(units). In DOZENS, an=2'b01 and seg=decode({2'b00,dozens}).
- Decode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Codes 10..15 show a dash, 3F.
- Leading-zero blanking: when blank_leading=1, registered dozens=0 and registered time_over=0, the DOZENS slot drives an=2'b11 and seg=7'h7F. The scan timing is unchanged.
- Blink:
  - While registered time_over=1, the blink counter counts to BLINK_CYCLES-1, then wraps and toggles the blink phase.
  - ON phase: both slots display "0" (seg=7'h40), regardless of the digit inputs and blank_leading.
  - OFF phase: an=2'b11 and seg=7'h7F in all states. The scan FSM keeps running.
  - When registered time_over falls, the blink counter clears and the phase returns to ON on the next cycle.
  - The first blink ON period after a time_over rise is a full BLINK_CYCLES cycles.
- Simultaneous events:
  - A scan state change and a blink toggle in the same cycle both take effect; the output reflects the new state and the new phase.
  - Input changes mid-slot appear 2 cycles later. No per-slot snapshot is taken.
- Reset mid-scan or mid-blink: all outputs are dark on the cycle after reset is asserted. Scanning restarts at UNITS with the dwell counter at 0.
- The an outputs are never 2'b00 in any cycle; a bench assertion is required.

Decomposition:
- Shared package timer_display_pkg holds:
  - the scan state enum (UNITS, GAP0, DOZENS, GAP1);
  - the segment constants SEG_BLANK=7'h7F, SEG_DASH=7'h3F, SEG_ZERO=7'h40;
  - the digit-enable constants AN_OFF=2'b11, AN_UNITS=2'b10, AN_DOZENS=2'b01.
- One sub-module, bcd_to_7seg: combinational 4-bit to 7-bit active-low decoder. It is reusable by other display stages.
- Scan FSM, dwell counter, blink counter and output registers live in the top module.

Test Plan:
(All with SCAN_CYCLES=4, BLINK_CYCLES=8.)
- Reset, then dozens=2, units=7, time_over=0, blank_leading=0:
  - Period of 10 cycles.
  - an sequence per period: 10 x4, 11 x1, 01 x4, 11 x1.
  - seg=78 with an=10; seg=24 with an=01.
- dozens=0, units=5, blank_leading=1: DOZENS slot shows an=11 and seg=7F; UNITS slot shows seg=12.
  - Set blank_leading=0: DOZENS slot shows seg=40.
- Countdown 01 -> 00 with time_over rising:
  - Two cycles later, both slots show 40 for 8 cycles, then dark for 8 cycles, repeating.
  - Drop time_over: display returns to normal within 2 cycles, blink phase ON.
- units=4'hC, dozens=1: UNITS slot shows seg=3F; DOZENS slot shows seg=79.
- Assert reset for 1 cycle mid-DOZENS slot and mid-blink:
  - Next cycle an=11, seg=7F.
  - Scan restarts with 4 cycles of UNITS.
- Run 1000 random cycles of input changes: assert an never equals 00, and a gap cycle (an=11) always separates the two digits.

Source files
------------

// File: rtl/timer_display_pkg.sv
// Shared types and constants for the two-digit countdown display driver.
// Segment codes are active-low, bit 0 = a through bit 6 = g.
package timer_display_pkg;

  typedef enum logic [1:0] {
    UNITS  = 2'd0,
    GAP0   = 2'd1,
    DOZENS = 2'd2,
    GAP1   = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_UNITS  = 2'b10;
  localparam logic [1:0] AN_DOZENS = 2'b01;

  function automatic scan_state_t next_scan_state(input scan_state_t s);
    case (s)
      UNITS:   return GAP0;
      GAP0:    return DOZENS;
      DOZENS:  return GAP1;
      default: return UNITS;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
  import timer_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/timer_display_driver.sv
// Two-digit multiplexed active-low display driver for the 30-to-0 countdown:
// scan with blank gaps between digits, optional leading-zero blanking, "00" blink.
module timer_display_driver
  import timer_display_pkg::*;
#(
  parameter int SCAN_CYCLES  = 50000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] dozens,
  input  logic [3:0] units,
  input  logic       time_over,
  input  logic       blank_leading,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int SCAN_W  = (SCAN_CYCLES  > 2) ? $clog2(SCAN_CYCLES)  : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [1:0]         dozens_p0;
  logic [3:0]         units_p0;
  logic               time_over_p0;

  scan_state_t        state_p1;
  logic [SCAN_W-1:0]  dwell_p1;
  logic [BLINK_W-1:0] blink_cnt_p1;
  logic               blink_off_p1;

  logic [3:0]         digit;
  logic [6:0]         digit_seg;
  logic [6:0]         seg_next;
  logic [1:0]         an_next;

  // Stage 0: input capture
  always_ff @(posedge clock) begin
    if (reset) begin
      dozens_p0    <= '0;
      units_p0     <= '0;
      time_over_p0 <= 1'b0;
    end else begin
      dozens_p0    <= dozens;
      units_p0     <= units;
      time_over_p0 <= time_over;
    end
  end

  // Stage 1: scan sequencer and blink timebase
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p1 <= UNITS;
      dwell_p1 <= '0;
    end else begin
      case (state_p1)
        UNITS, DOZENS: begin
          if (dwell_p1 == SCAN_LAST) begin
            state_p1 <= next_scan_state(state_p1);
            dwell_p1 <= '0;
          end else begin
            dwell_p1 <= dwell_p1 + 1'b1;
          end
        end
        default: begin
          state_p1 <= next_scan_state(state_p1);
          dwell_p1 <= '0;
        end
      endcase
    end
  end

  // Blink restarts from a full ON half-period whenever time_over is low.
  always_ff @(posedge clock) begin
    if (reset || !time_over_p0) begin
      blink_cnt_p1 <= '0;
      blink_off_p1 <= 1'b0;
    end else if (blink_cnt_p1 == BLINK_LAST) begin
      blink_cnt_p1 <= '0;
      blink_off_p1 <= ~blink_off_p1;
    end else begin
      blink_cnt_p1 <= blink_cnt_p1 + 1'b1;
    end
  end

  // Stage 2: digit select, decode and output registers
  assign digit = (state_p1 == DOZENS) ? {2'b00, dozens_p0} : units_p0;

  bcd_to_7seg u_decode (
    .digit (digit),
    .seg   (digit_seg)
  );

  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = AN_OFF;
    case (state_p1)
      UNITS: begin
        an_next  = AN_UNITS;
        seg_next = time_over_p0 ? SEG_ZERO : digit_seg;
      end
      DOZENS: begin
        if (time_over_p0 || !(blank_leading && dozens_p0 == 2'd0)) begin
          an_next  = AN_DOZENS;
          seg_next = time_over_p0 ? SEG_ZERO : digit_seg;
        end
      end
      default: begin
        seg_next = SEG_BLANK;
        an_next  = AN_OFF;
      end
    endcase
    if (time_over_p0 && blink_off_p1) begin
      seg_next = SEG_BLANK;
      an_next  = AN_OFF;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_timer_display_driver.sv
// Directed bench for timer_display_driver with SCAN_CYCLES=4, BLINK_CYCLES=8.
// ph tracks the scan slot position (0-3 units, 4 gap, 5-8 dozens, 9 gap) of the visible output.
module tb_timer_display_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dozens = 2'd0;
  logic [3:0] units = 4'd0;
  logic       time_over = 1'b0;
  logic       blank_leading = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;

  int tests = 0;
  int fails = 0;
  int ph = 9;

  timer_display_driver #(
    .SCAN_CYCLES  (4),
    .BLINK_CYCLES (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .dozens        (dozens),
    .units         (units),
    .time_over     (time_over),
    .blank_leading (blank_leading),
    .seg           (seg),
    .an            (an)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    assert (an !== 2'b00) else $error("FAIL an_never_00: an=%b", an);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [1:0] exp_an(input int p);
    if (p <= 3) return 2'b10;
    if (p >= 5 && p <= 8) return 2'b01;
    return 2'b11;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    ph = (ph + 1) % 10;
  endtask

  task automatic test_reset();
    dozens = 2'd2; units = 4'd7; time_over = 1'b0; blank_leading = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if (an !== 2'b11) begin fails++; $display("FAIL reset_an: got %b want 11", an); end
    tests++;
    if (seg !== 7'h7F) begin fails++; $display("FAIL reset_seg: got %h want 7f", seg); end
    reset = 1'b0;
    ph = 9;
  endtask

  task automatic test_scan();
    logic [1:0] ea;
    logic [6:0] es;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      ea = exp_an(ph);
      es = (ea == 2'b10) ? 7'h78 : (ea == 2'b01) ? 7'h24 : 7'h7F;
      tests++;
      if (an !== ea) begin fails++; $display("FAIL scan_an ph=%0d: got %b want %b", ph, an, ea); end
      tests++;
      if (seg !== es) begin fails++; $display("FAIL scan_seg ph=%0d: got %h want %h", ph, seg, es); end
    end
  endtask

  task automatic test_blank_leading();
    logic [1:0] ea;
    logic [6:0] es;
    dozens = 2'd0; units = 4'd5; blank_leading = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      ea = (exp_an(ph) == 2'b01) ? 2'b11 : exp_an(ph);
      es = (ea == 2'b10) ? 7'h12 : 7'h7F;
      tests++;
      if (an !== ea) begin fails++; $display("FAIL blank_an ph=%0d: got %b want %b", ph, an, ea); end
      tests++;
      if (seg !== es) begin fails++; $display("FAIL blank_seg ph=%0d: got %h want %h", ph, seg, es); end
    end
    blank_leading = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      ea = exp_an(ph);
      es = (ea == 2'b10) ? 7'h12 : (ea == 2'b01) ? 7'h40 : 7'h7F;
      tests++;
      if (an !== ea) begin fails++; $display("FAIL noblank_an ph=%0d: got %b want %b", ph, an, ea); end
      tests++;
      if (seg !== es) begin fails++; $display("FAIL noblank_seg ph=%0d: got %h want %h", ph, seg, es); end
    end
  endtask

  task automatic test_blink();
    logic [1:0] ea;
    logic [6:0] es;
    logic       on;
    dozens = 2'd0; units = 4'd1; time_over = 1'b0; blank_leading = 1'b0;
    repeat (3) tick();
    units = 4'd0; time_over = 1'b1;
    for (int m = 1; m <= 25; m++) begin
      tick();
      if (m >= 2) begin
        on = (((m - 2) / 8) % 2) == 0;
        ea = on ? exp_an(ph) : 2'b11;
        es = (ea == 2'b11) ? 7'h7F : 7'h40;
        tests++;
        if (an !== ea) begin fails++; $display("FAIL blink_an m=%0d: got %b want %b", m, an, ea); end
        tests++;
        if (seg !== es) begin fails++; $display("FAIL blink_seg m=%0d: got %h want %h", m, seg, es); end
      end
    end
    time_over = 1'b0; units = 4'd3;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      ea = exp_an(ph);
      es = (ea == 2'b10) ? 7'h30 : (ea == 2'b01) ? 7'h40 : 7'h7F;
      tests++;
      if (an !== ea) begin fails++; $display("FAIL unblink_an ph=%0d: got %b want %b", ph, an, ea); end
      tests++;
      if (seg !== es) begin fails++; $display("FAIL unblink_seg ph=%0d: got %h want %h", ph, seg, es); end
    end
    time_over = 1'b1;
    tick();
    for (int m = 2; m <= 10; m++) begin
      tick();
      ea = (m <= 9) ? exp_an(ph) : 2'b11;
      tests++;
      if (an !== ea) begin fails++; $display("FAIL reblink_an m=%0d: got %b want %b", m, an, ea); end
    end
    time_over = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_dash();
    logic [1:0] ea;
    logic [6:0] es;
    units = 4'hC; dozens = 2'd1; time_over = 1'b0; blank_leading = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      ea = exp_an(ph);
      es = (ea == 2'b10) ? 7'h3F : (ea == 2'b01) ? 7'h79 : 7'h7F;
      tests++;
      if (an !== ea) begin fails++; $display("FAIL dash_an ph=%0d: got %b want %b", ph, an, ea); end
      tests++;
      if (seg !== es) begin fails++; $display("FAIL dash_seg ph=%0d: got %h want %h", ph, seg, es); end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    dozens = 2'd1; units = 4'd2; time_over = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (ph == 6) found = 1'b1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL reset_mid_align: got no dozens slot want ph 6"); end
    reset = 1'b1;
    tick();
    tests++;
    if (an !== 2'b11) begin fails++; $display("FAIL reset_mid_an: got %b want 11", an); end
    tests++;
    if (seg !== 7'h7F) begin fails++; $display("FAIL reset_mid_seg: got %h want 7f", seg); end
    reset = 1'b0; time_over = 1'b0;
    ph = 9;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (an !== 2'b10) begin fails++; $display("FAIL restart_an i=%0d: got %b want 10", i, an); end
      tests++;
      if (seg !== ((i == 0) ? 7'h40 : 7'h24)) begin
        fails++; $display("FAIL restart_seg i=%0d: got %h want %h", i, seg, (i == 0) ? 7'h40 : 7'h24);
      end
    end
    tick();
    tests++;
    if (an !== 2'b11) begin fails++; $display("FAIL restart_gap_an: got %b want 11", an); end
  endtask

  task automatic test_random();
    logic [1:0] prev_an = 2'b11;
    for (int i = 0; i < 1000; i++) begin
      dozens = 2'($urandom_range(0, 3));
      units = 4'($urandom_range(0, 15));
      time_over = ($urandom_range(0, 7) == 0);
      blank_leading = 1'($urandom_range(0, 1));
      tick();
      tests++;
      if (an === 2'b00) begin fails++; $display("FAIL rand_an00 i=%0d: got %b want not 00", i, an); end
      tests++;
      if (an !== 2'b11 && an !== exp_an(ph)) begin
        fails++; $display("FAIL rand_slot i=%0d: got %b want %b or 11", i, an, exp_an(ph));
      end
      tests++;
      if ((prev_an == 2'b10 && an == 2'b01) || (prev_an == 2'b01 && an == 2'b10)) begin
        fails++; $display("FAIL rand_gap i=%0d: got %b after %b want 11 between", i, an, prev_an);
      end
      prev_an = an;
    end
    time_over = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank_leading();
    test_blink();
    test_dash();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
